// File: rtl/sccb_init_seq.sv
// Walks an SCCB register table and issues one iic_driver write per entry, with delay entries, NACK/timeout retry and a completion watchdog.
// Optional read-back verification of each write is built when SCCB_VERIFY_EN is defined.
module sccb_init_seq #(
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned DELAY_CYCLES   = 1000000,
  parameter int unsigned IDX_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] rom_index,
  input  logic [15:0]      rom_entry,
  output logic             iic_wr_en,
  output logic             iic_rd_en,
  output logic [7:0]       iic_addr,
  inout  wire  [7:0]       iic_data,
  input  logic             iic_work_done,
  input  logic             iic_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic [15:0]      debug_out
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_ISSUE     = 4'd3,
    ST_WAIT      = 4'd4,
    ST_RETRY     = 4'd5,
    ST_DELAY     = 4'd6,
    ST_NEXT      = 4'd7,
    ST_DONE      = 4'd8,
    ST_FAIL      = 4'd9,
    ST_VRD_ISSUE = 4'd10,
    ST_VRD_WAIT  = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rom_index_q, rom_index_d;
  logic [15:0]      entry_q, entry_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             wr_en_q, wr_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_cnt_q, retry_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [IDX_W-1:0] err_index_q, err_index_d;
`ifdef SCCB_VERIFY_EN
  logic             rd_en_q, rd_en_d;
  logic             oe_q, oe_d;
  logic             soft_reset_entry;
  assign soft_reset_entry = (entry_q[15:8] == 8'h12) && entry_q[7];
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rom_index_q <= '0;
      entry_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      cnt_q       <= '0;
      retry_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
`ifdef SCCB_VERIFY_EN
      rd_en_q     <= 1'b0;
      oe_q        <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      rom_index_q <= rom_index_d;
      entry_q     <= entry_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      cnt_q       <= cnt_d;
      retry_cnt_q <= retry_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
`ifdef SCCB_VERIFY_EN
      rd_en_q     <= rd_en_d;
      oe_q        <= oe_d;
`endif
    end
  end

  // Next-state logic; strobes are raised on the transition into the issue states
  always_comb begin
    state_d     = state_q;
    rom_index_d = rom_index_q;
    entry_d     = entry_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_en_d     = 1'b0;
    cnt_d       = cnt_q;
    retry_cnt_d = retry_cnt_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;
`ifdef SCCB_VERIFY_EN
    rd_en_d     = 1'b0;
    oe_d        = oe_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          done_d      = 1'b0;
          error_d     = 1'b0;
          retry_cnt_d = '0;
          rom_index_d = '0;
          state_d     = ST_FETCH;
        end
      end

      ST_FETCH: state_d = ST_DECODE;

      ST_DECODE: begin
        entry_d = rom_entry;
        cnt_d   = '0;
        if (rom_entry == 16'hFFFF) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (rom_entry[15:8] == 8'hFE) begin
          state_d = ST_DELAY;
        end else begin
          addr_d  = rom_entry[15:8];
          data_d  = rom_entry[7:0];
          wr_en_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: state_d = ST_WAIT;

      // First cycle after the strobe ignores work_done; work_done beats timeout
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if ((cnt_q != '0) && iic_work_done) begin
          if (iic_ack) begin
`ifdef SCCB_VERIFY_EN
            if (soft_reset_entry) begin
              state_d = ST_NEXT;
            end else begin
              rd_en_d = 1'b1;
              oe_d    = 1'b0;
              cnt_d   = '0;
              state_d = ST_VRD_ISSUE;
            end
`else
            state_d = ST_NEXT;
`endif
          end else begin
            state_d = ST_RETRY;
          end
        end else if (cnt_q >= TMO_LAST) begin
          state_d = ST_RETRY;
        end
      end

`ifdef SCCB_VERIFY_EN
      ST_VRD_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_VRD_WAIT;
      end

      ST_VRD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if ((cnt_q != '0) && iic_work_done) begin
          oe_d    = 1'b1;
          state_d = (iic_ack && (iic_data == entry_q[7:0])) ? ST_NEXT : ST_RETRY;
        end else if (cnt_q >= TMO_LAST) begin
          oe_d    = 1'b1;
          state_d = ST_RETRY;
        end
      end
`endif

      // Retry re-issues the latched entry without another table fetch
      ST_RETRY: begin
        if (32'(retry_cnt_q) < MAX_RETRY) begin
          retry_cnt_d = retry_cnt_q + 4'd1;
          cnt_d       = '0;
          wr_en_d     = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          err_index_d = rom_index_q;
          error_d     = 1'b1;
          state_d     = ST_FAIL;
        end
      end

      ST_DELAY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q >= DLY_LAST) begin
          state_d = ST_NEXT;
        end
      end

      // A table with no end marker finishes after its last addressable entry
      ST_NEXT: begin
        retry_cnt_d = '0;
        if (rom_index_q == '1) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          rom_index_d = rom_index_q + IDX_W'(1);
          state_d     = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_FAIL));
  end

  assign rom_index = rom_index_q;
  assign iic_wr_en = wr_en_q;
  assign iic_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;
  assign debug_out = {state_q, retry_cnt_q, 8'(rom_index_q)};

`ifdef SCCB_VERIFY_EN
  assign iic_rd_en = rd_en_q;
  assign iic_data  = oe_q ? data_q : 8'bz;
`else
  assign iic_rd_en = 1'b0;
  assign iic_data  = data_q;
`endif

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: directed table vectors, timeout/reset corner sequences and
// randomized tables checked against a table-walk reference model.
module tb_sccb_init_seq;

  localparam int MAX_RETRY = 2;
  localparam int TIMEOUT   = 50;
  localparam int DELAY     = 40;
  localparam int IDX_W     = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W-1:0] rom_index;
  logic [15:0]      rom_entry;
  logic             iic_wr_en, iic_rd_en;
  logic [7:0]       iic_addr;
  wire  [7:0]       iic_data;
  logic             iic_work_done, iic_ack;
  logic             busy, done, error;
  logic [IDX_W-1:0] err_index;
  logic [15:0]      debug_out;

  sccb_init_seq #(
    .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYCLES(TIMEOUT), .DELAY_CYCLES(DELAY), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rom_index(rom_index), .rom_entry(rom_entry),
    .iic_wr_en(iic_wr_en), .iic_rd_en(iic_rd_en), .iic_addr(iic_addr), .iic_data(iic_data),
    .iic_work_done(iic_work_done), .iic_ack(iic_ack), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .debug_out(debug_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] ents;
    logic [3:0][3:0]  nk;
    logic [7:0]       n_wr;
    logic             dn;
    logic             er;
    logic [7:0]       eidx;
    logic [7:0]       fin;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
    bit         rd;
  } ev_t;

  logic [15:0] rom [256];
  int          nack_cfg [256];
  ev_t         wr_log [$];
  logic [15:0] exp_wr [$];
  bit          exp_done, exp_err;
  int          exp_eidx, exp_fin;
  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0;
  int          run_id = 0;
  int          bad_rd_run = -1;
  bit          no_resp = 1'b0;
  int          end_cyc;

  // Driver-model state
  bit          drv_pend = 1'b0, drv_ack = 1'b0, drv_en = 1'b0, drv_release = 1'b0;
  int          drv_cnt = 0, drv_att = 0, drv_rdc = 0, drv_last_idx = -1, drv_seen_run = -1;
  logic [7:0]  drv_wdata = 8'h00, drv_val = 8'h00;

`ifdef SCCB_VERIFY_EN
  assign iic_data = drv_en ? drv_val : 8'bz;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Table ROM: entry follows the index within the same cycle's low phase
  always @(negedge clk) rom_entry = rom[rom_index];

  // iic_driver model: per-entry NACK budget, random completion latency, optional bad readback
  always @(negedge clk) begin
    iic_work_done = 1'b0;
    iic_ack       = 1'b0;
    if (drv_release) begin
      drv_en      = 1'b0;
      drv_release = 1'b0;
    end
    if (!rst) begin
      drv_pend = 1'b0;
      drv_en   = 1'b0;
    end else begin
      if (drv_seen_run != run_id) begin
        drv_seen_run = run_id;
        drv_last_idx = -1;
        drv_rdc      = 0;
      end
      if (iic_wr_en) begin
        if (int'(rom_index) != drv_last_idx) begin
          drv_att      = 0;
          drv_last_idx = int'(rom_index);
        end
        drv_att++;
        drv_ack   = drv_att > nack_cfg[rom_index];
        drv_wdata = iic_data;
        drv_pend  = 1'b1;
        drv_cnt   = $urandom_range(2, 5);
      end else if (iic_rd_en) begin
        drv_rdc++;
        drv_ack  = 1'b1;
        drv_val  = (bad_rd_run == run_id && drv_rdc == 1) ? drv_wdata + 8'd1 : drv_wdata;
        drv_en   = 1'b1;
        drv_pend = 1'b1;
        drv_cnt  = $urandom_range(2, 5);
      end else if (drv_pend && !no_resp) begin
        drv_cnt--;
        if (drv_cnt == 0) begin
          iic_work_done = 1'b1;
          iic_ack       = drv_ack;
          drv_pend      = 1'b0;
          if (drv_en) drv_release = 1'b1;
        end
      end
    end
  end

  // Bus monitor
  always @(negedge clk) begin
    if (rst && (iic_wr_en || iic_rd_en))
      wr_log.push_back('{cyc, iic_addr, iic_data, iic_rd_en});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 256; i++) begin
      rom[i]      = 16'hFFFF;
      nack_cfg[i] = 0;
    end
  endtask

  // Reference: walk the table, each write entry takes min(nacks, MAX_RETRY)+1 attempts
  task automatic model();
    int n;
    exp_wr.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_eidx = 0; exp_fin = 0;
    for (int i = 0; i < 256; i++) begin
      if (rom[i] == 16'hFFFF) begin
        exp_done = 1'b1; exp_fin = i;
        return;
      end
      if (rom[i][15:8] != 8'hFE) begin
        n = (nack_cfg[i] > MAX_RETRY) ? MAX_RETRY + 1 : nack_cfg[i] + 1;
        repeat (n) exp_wr.push_back(rom[i]);
        if (nack_cfg[i] > MAX_RETRY) begin
          exp_err = 1'b1; exp_eidx = i; exp_fin = i;
          return;
        end
      end
    end
    exp_done = 1'b1; exp_fin = 255;
  endtask

  task automatic run_seq(input string nm);
    bit fin;
    run_id++;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (done || error) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    end_cyc = cyc;
    chk({nm, "_finished"}, 32'(done | error), 32'd1);
  endtask

  task automatic check_run(input string nm, input int base, output int nw);
    nw = 0;
    for (int k = base; k < wr_log.size(); k++) begin
      if (!wr_log[k].rd) begin
        if (nw < exp_wr.size()) chk({nm, "_wr"}, 32'({wr_log[k].a, wr_log[k].d}), 32'(exp_wr[nw]));
        nw++;
      end
    end
    chk({nm, "_nwr"}, 32'(nw), 32'(exp_wr.size()));
    chk({nm, "_done"}, 32'(done), 32'(exp_done));
    chk({nm, "_error"}, 32'(error), 32'(exp_err));
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_index"}, 32'(rom_index), 32'(exp_fin));
    chk({nm, "_dbg_idx"}, 32'(debug_out[7:0]), 32'(exp_fin));
    chk({nm, "_dbg_retry"}, 32'(debug_out[11:8]), exp_err ? 32'(MAX_RETRY) : 32'd0);
    if (exp_err) chk({nm, "_err_index"}, 32'(err_index), 32'(exp_eidx));
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_wr_en"}, 32'(iic_wr_en), 32'd0);
    chk({nm, "_rd_en"}, 32'(iic_rd_en), 32'd0);
    chk({nm, "_addr"}, 32'(iic_addr), 32'd0);
    chk({nm, "_data"}, 32'(iic_data), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_error"}, 32'(error), 32'd0);
    chk({nm, "_index"}, 32'(rom_index), 32'd0);
    chk({nm, "_debug"}, 32'(debug_out), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    int   base, nw, gap, diff, last_wr, seen, r, len;
    string nm;

    vecs[0] = '{ents: {16'hFFFF, 16'h1101, 16'hFE00, 16'h1280}, nk: 16'h0000,
                n_wr: 8'd2, dn: 1'b1, er: 1'b0, eidx: 8'd0, fin: 8'd3};
    vecs[1] = '{ents: {16'h0000, 16'h0000, 16'hFFFF, 16'h3A04}, nk: 16'h0002,
                n_wr: 8'd3, dn: 1'b1, er: 1'b0, eidx: 8'd0, fin: 8'd1};
    vecs[2] = '{ents: {16'h0000, 16'h0000, 16'hFFFF, 16'h40D0}, nk: 16'h000F,
                n_wr: 8'd3, dn: 1'b0, er: 1'b1, eidx: 8'd0, fin: 8'd0};
    vecs[3] = '{ents: {16'hFFFF, 16'h5566, 16'h3344, 16'h1122}, nk: 16'h00F0,
                n_wr: 8'd4, dn: 1'b0, er: 1'b1, eidx: 8'd1, fin: 8'd1};
    vecs[4] = '{ents: {16'h0000, 16'hFFFF, 16'h7788, 16'h1122}, nk: 16'h0011,
                n_wr: 8'd4, dn: 1'b1, er: 1'b0, eidx: 8'd0, fin: 8'd2};

    clear_table();
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table vectors
    for (int v = 0; v < 5; v++) begin
      nm = $sformatf("vec%0d", v);
      clear_table();
      for (int i = 0; i < 4; i++) begin
        rom[i]      = vecs[v].ents[i];
        nack_cfg[i] = int'(vecs[v].nk[i]);
      end
      model();
      base = wr_log.size();
      run_seq(nm);
      check_run(nm, base, nw);
      chk({nm, "_nwr_const"}, 32'(nw), 32'(vecs[v].n_wr));
      chk({nm, "_done_const"}, 32'(done), 32'(vecs[v].dn));
      chk({nm, "_error_const"}, 32'(error), 32'(vecs[v].er));
      chk({nm, "_index_const"}, 32'(rom_index), 32'(vecs[v].fin));
      if (vecs[v].er) chk({nm, "_eidx_const"}, 32'(err_index), 32'(vecs[v].eidx));
      if (v == 0 && wr_log.size() >= base + 2) begin
        gap = wr_log[base + 1].cyc - wr_log[base].cyc;
        chk("vec0_delay_gap", (gap >= DELAY) ? 32'(DELAY) : 32'(gap), 32'(DELAY));
      end
    end

    // Driver never completes: every attempt times out, then FAIL
    clear_table();
    rom[0] = 16'h40D0;
    nack_cfg[0] = 15;
    no_resp = 1'b1;
    model();
    base = wr_log.size();
    run_seq("tmo");
    check_run("tmo", base, nw);
    last_wr = (wr_log.size() > base) ? wr_log[wr_log.size() - 1].cyc : 0;
    diff = end_cyc - last_wr;
    chk("tmo_latency", (diff >= 51 && diff <= 53) ? 32'd52 : 32'(diff), 32'd52);

    // Start during WAIT is ignored; reset mid-WAIT clears outputs at once
    clear_table();
    rom[0] = 16'h3A04;
    base = wr_log.size();
    run_id++;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (wr_log.size() > base) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("busy_start_strobe_seen", 32'(wr_log.size() - base), 32'd1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_start_no_extra_wr", 32'(wr_log.size() - base), 32'd1);
    chk("busy_start_busy", 32'(busy), 32'd1);
    chk("busy_start_addr", 32'(iic_addr), 32'h3A);
    chk("busy_start_data", 32'(iic_data), 32'h04);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk) rst = 1'b1;
    no_resp = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized tables against the reference model
    for (int it = 0; it < 12; it++) begin
      nm = $sformatf("rnd%0d", it);
      clear_table();
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 4) == 0) rom[j] = {8'hFE, 8'($urandom)};
        else rom[j] = {8'($urandom_range(0, 253)), 8'($urandom)};
        r = $urandom_range(0, 9);
        nack_cfg[j] = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
      end
      model();
      base = wr_log.size();
      run_seq(nm);
      check_run(nm, base, nw);
    end

`ifdef SCCB_VERIFY_EN
    // First readback is wrong, so the entry is rewritten and read again
    clear_table();
    rom[0] = 16'h3A04;
    bad_rd_run = run_id + 1;
    base = wr_log.size();
    run_seq("vrd");
    chk("vrd_events", 32'(wr_log.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < wr_log.size()) begin
        chk($sformatf("vrd_kind%0d", k), 32'(wr_log[base + k].rd), 32'(k % 2));
        chk($sformatf("vrd_addr%0d", k), 32'(wr_log[base + k].a), 32'h3A);
      end
    end
    chk("vrd_done", 32'(done), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
